// File: rtl/param_vec_streamer.sv
// Fetches one VEC_LEN-element vector from a combinational parameter LUT and streams it out
// element by element with valid/ready handshaking. Optional PARAM_ADDR_CHECK_EN adds an err pulse for unknown addresses.
module param_vec_streamer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LEN    = 16,
    localparam int IDX_W     = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      req_valid,
    output logic                                      req_ready,
    input  logic        [ADDR_WIDTH-1:0]              req_addr,
    output logic        [ADDR_WIDTH-1:0]              lut_addr,
    input  logic signed [VEC_LEN-1:0][DATA_WIDTH-1:0] lut_data,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic signed [DATA_WIDTH-1:0]              out_data,
    output logic        [IDX_W-1:0]                   out_idx,
    output logic                                      out_last,
`ifdef PARAM_ADDR_CHECK_EN
    output logic                                      err,
`endif
    output logic                                      busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        STREAM = 2'd2
    } state_e;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

    state_e                        state_q, state_d;
    logic        [ADDR_WIDTH-1:0]  addr_q;
    logic        [IDX_W-1:0]       idx_q, idx_d;
    logic signed [DATA_WIDTH-1:0]  vec_q [VEC_LEN];
    logic                          acceptReq;
    logic                          lastElem;
    logic                          fetchDrop;

    assign acceptReq = (state_q == IDLE) && req_valid;
    assign lastElem  = (idx_q == LAST_IDX);
    assign lut_addr  = addr_q;

`ifdef PARAM_ADDR_CHECK_EN
    function automatic logic addrKnown(input logic [ADDR_WIDTH-1:0] a);
        case (a)
            ADDR_WIDTH'(8'h03), ADDR_WIDTH'(8'h04), ADDR_WIDTH'(8'h05),
            ADDR_WIDTH'(8'h06), ADDR_WIDTH'(8'h08), ADDR_WIDTH'(8'h0A),
            ADDR_WIDTH'(8'h0C), ADDR_WIDTH'(8'h0E), ADDR_WIDTH'(8'h10): return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // FETCH lasts one cycle, so flagging it there gives a single-cycle err pulse
    assign fetchDrop = (state_q == FETCH) && !addrKnown(addr_q);
    assign err       = fetchDrop;
`else
    assign fetchDrop = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                idx_d   = '0;
                state_d = fetchDrop ? IDLE : STREAM;
            end
            STREAM: begin
                if (out_ready) begin
                    if (lastElem) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        busy      = (state_q != IDLE);
        out_valid = (state_q == STREAM);
        out_idx   = idx_q;
        out_last  = (state_q == STREAM) && lastElem;
        out_data  = (state_q == STREAM) ? vec_q[idx_q] : '0;
    end

    // The buffer snapshots the LUT only in FETCH, isolating the stream from later LUT changes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            idx_q  <= '0;
            for (int i = 0; i < VEC_LEN; i++) begin
                vec_q[i] <= '0;
            end
        end else begin
            if (acceptReq) begin
                addr_q <= req_addr;
            end
            if (state_q == FETCH) begin
                for (int i = 0; i < VEC_LEN; i++) begin
                    vec_q[i] <= lut_data[i];
                end
            end
            idx_q <= idx_d;
        end
    end

endmodule
